dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Memory-side responder for the core's data-memory port. It accepts one load/store request at a time over a valid/ready request channel and stalls for a configurable number of wait states. It then returns read data and an error flag over a valid/ready response channel. Storage is a word-addressed array with byte-lane write strobes. Requests carry a region-relative byte address and a strobe mask, already sized and aligned by the load-store unit.

Parameters:
XLEN, 32, data and address width in bits.
BYTE_WIDTH, 8, bits per strobe lane; XLEN/BYTE_WIDTH lanes.
DEPTH_WORDS, 1024, number of XLEN-bit words in storage.
WAIT_CYCLES, 1, wait states between acceptance and response; legal range 0..15.

Ports:
i_clk  in  1  clock; all state changes on the rising edge.
i_rst  in  1  synchronous, active-high reset.
i_req_valid  in  1  request present.
o_req_ready  out  1  responder can accept a request.
i_req_we  in  1  1 = store, 0 = load.
i_req_addr  in  XLEN  region-relative byte address.
i_req_wdata  in  XLEN  store data, lane-aligned (byte in [7:0], half in [15:0]).
i_req_wstrb  in  XLEN/BYTE_WIDTH  byte-lane write enables.
o_resp_valid  out  1  response present.
i_resp_ready  in  1  initiator takes the response.
o_resp_rdata  out  XLEN  load data (full word).
o_resp_err  out  1  access fault: address out of range.

Behaviour:
- Reset: state IDLE. o_req_ready=0 during the reset cycle. o_resp_valid=0, o_resp_rdata=0, o_resp_err=0. Internal counter=0. Storage contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - o_req_ready=1.
  - On an edge with i_req_valid=1, register we, addr, wdata and wstrb (the acceptance edge).
  - Set err_q = (i_req_addr[XLEN-1:2] >= DEPTH_WORDS).
  - Next state is WAIT with counter=WAIT_CYCLES if WAIT_CYCLES>0, else RESP.
- WAIT:
  - o_req_ready=0; the counter decrements each edge.
  - When counter==1, the next state is RESP.
- Transition into RESP (the commit edge):
  - Load, err_q=0: o_resp_rdata <= mem[addr_q[..:2]].
  - Store, err_q=0: for each lane i with wstrb_q[i]=1, update that lane of the word with wdata_q; o_resp_rdata <= 0.
  - err_q=1: no storage update, o_resp_rdata <= 0.
  - o_resp_err <= err_q.
- RESP:
  - o_resp_valid=1 and o_req_ready=0.
  - rdata and err are held stable until an edge with i_resp_ready=1.
  - On that edge: o_resp_valid <= 0, rdata/err <= 0, state returns to IDLE.
  - The next request can be accepted no earlier than the edge after the response handshake; there is no overlap.
- Latency: o_resp_valid rises exactly WAIT_CYCLES+1 edges after the acceptance edge, counting the acceptance edge as the first.
- Address handling:
  - addr[1:0] are ignored for indexing; the full aligned word is always returned.
  - Sign/zero extension and lane selection are the initiator's responsibility.
- Store with wstrb=0: a legal no-op; it still produces a normal response with err=0.
- i_req_* inputs are ignored whenever o_req_ready=0.
- Reset mid-operation:
  - Any in-flight request is dropped and state goes to IDLE.
  - A store still in WAIT at the reset edge is never committed.
  - A store already committed (in RESP) stays written.
- Boundaries:
  - Word index DEPTH_WORDS-1 is valid; DEPTH_WORDS and above are faults.
  - No wrap-around of the index.

Test Plan:
- Reset, WAIT_CYCLES=1: assert i_rst 2 cycles -> o_resp_valid=0, o_resp_err=0, o_resp_rdata=0; o_req_ready=1 on the first cycle after reset deasserts.
- Full-word store then load at 0x10:
  - Store 0xDEADBEEF with wstrb=1111, then load 0x10 -> load returns 0xDEADBEEF, err=0.
  - o_resp_valid rises 2 edges after each acceptance.
- Partial-strobe stores:
  - Word 0x20 holds 0x11223344; store wdata 0x000000AA, wstrb=0001 -> load returns 0x112233AA.
  - Then store wdata 0x0000BBCC, wstrb=0011 at 0x22 -> load 0x20 returns 0x1122BBCC (addr[1:0] ignored).
- Out-of-range address, DEPTH_WORDS=1024:
  - Store to byte address 0x1000 -> err=1, storage unchanged.
  - Load 0x1000 -> err=1, rdata=0.
  - Load 0xFFC -> err=0.
- Response backpressure: hold i_resp_ready=0 for 5 cycles during a load -> o_resp_valid/rdata stable all 5 cycles, o_req_ready=0; release -> IDLE on the next edge.
- WAIT_CYCLES=0 vs 3, plus reset mid-wait:
  - WAIT_CYCLES=0: response valid in the cycle after acceptance.
  - WAIT_CYCLES=3: response valid after 4 edges.
  - Assert i_rst during WAIT of a store of 0x55 to 0x40 -> a later load of 0x40 returns the old value.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's data-memory port.
// Takes one load/store at a time over a valid/ready request channel, waits
// WAIT_CYCLES wait states, commits the access to a word-addressed store with
// byte-lane strobes, then holds the response until the initiator takes it.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_req_valid/o_req_ready   request handshake
//   i_req_we             1 = store, 0 = load
//   i_req_addr           region-relative byte address (low bits ignored)
//   i_req_wdata/wstrb    lane-aligned store data and byte-lane enables
//   o_resp_valid/i_resp_ready response handshake
//   o_resp_rdata         full aligned word on loads, 0 otherwise
//   o_resp_err           address beyond DEPTH_WORDS
module dmem_responder #(
  parameter int XLEN        = 32,
  parameter int BYTE_WIDTH  = 8,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic                       i_req_we,
  input  logic [XLEN-1:0]            i_req_addr,
  input  logic [XLEN-1:0]            i_req_wdata,
  input  logic [XLEN/BYTE_WIDTH-1:0] i_req_wstrb,
  output logic                       o_resp_valid,
  input  logic                       i_resp_ready,
  output logic [XLEN-1:0]            o_resp_rdata,
  output logic                       o_resp_err
);
  localparam int NUM_LANES = XLEN / BYTE_WIDTH;
  localparam int OFF_W     = $clog2(NUM_LANES);
  localparam int IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic                 we;
    logic                 err;
    logic [IDX_W-1:0]     idx;
    logic [XLEN-1:0]      wdata;
    logic [NUM_LANES-1:0] wstrb;
  } req_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  req_t       req_in, req_q, req_c;
  logic       accept, commit;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  // Byte offset within the word never selects anything; the whole word moves.
  logic unused_addr_lo;
  assign unused_addr_lo = ^i_req_addr[OFF_W-1:0];

  always_comb begin
    req_in.we    = i_req_we;
    // Range check on the full word index so large addresses never alias.
    req_in.err   = ({{OFF_W{1'b0}}, i_req_addr[XLEN-1:OFF_W]} >= XLEN'(DEPTH_WORDS));
    req_in.idx   = i_req_addr[OFF_W +: IDX_W];
    req_in.wdata = i_req_wdata;
    req_in.wstrb = i_req_wstrb;
  end

  assign o_req_ready = (state_q == S_IDLE) && !i_rst;
  assign accept      = (state_q == S_IDLE) && i_req_valid;

  // With no wait states the acceptance edge is also the commit edge, so the
  // access must be served straight from the request inputs.
  assign req_c  = ZERO_WAIT ? req_in : req_q;
  assign commit = ZERO_WAIT ? accept : ((state_q == S_WAIT) && (cnt_q == 4'd1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (i_req_valid) begin
        if (ZERO_WAIT) state_d = S_RESP;
        else begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP: if (i_resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      req_q        <= '0;
      o_resp_valid <= 1'b0;
      o_resp_rdata <= '0;
      o_resp_err   <= 1'b0;
    end else begin
      if (accept) req_q <= req_in;
      if (commit) begin
        o_resp_valid <= 1'b1;
        o_resp_err   <= req_c.err;
        o_resp_rdata <= (!req_c.err && !req_c.we) ? mem[req_c.idx] : '0;
      end else if ((state_q == S_RESP) && i_resp_ready) begin
        o_resp_valid <= 1'b0;
        o_resp_rdata <= '0;
        o_resp_err   <= 1'b0;
      end
    end
  end

  // Storage is never cleared; a reset on the commit edge cancels the write.
  always_ff @(posedge i_clk) begin
    if (commit && !i_rst && req_c.we && !req_c.err) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (req_c.wstrb[l])
          mem[req_c.idx][l*BYTE_WIDTH +: BYTE_WIDTH] <= req_c.wdata[l*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Three instances share a clock, reset and
// request fields: [0] WAIT_CYCLES=1, [1] WAIT_CYCLES=0, [2] WAIT_CYCLES=3.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_ready = 1'b0;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err [3];

  int asserts = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYCLES(1)) dut_w1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_resp_valid(resp_valid[0]), .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata[0]), .o_resp_err(resp_err[0]));

  dmem_responder #(.WAIT_CYCLES(0)) dut_w0 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_resp_valid(resp_valid[1]), .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata[1]), .o_resp_err(resp_err[1]));

  dmem_responder #(.WAIT_CYCLES(3)) dut_w3 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_resp_valid(resp_valid[2]), .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata[2]), .o_resp_err(resp_err[2]));

  // Present a request at a falling edge; the next rising edge accepts it.
  task automatic send_req(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    req_valid[d] = 1'b1;
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
  endtask

  // Edges from acceptance (counted as 1) until valid is seen; -1 on timeout.
  task automatic wait_resp(input int d, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (resp_valid[d] === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic txn(input int d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wstrb,
                     output logic [31:0] rdata, output logic err, output int lat);
    send_req(d, we, addr, wdata, wstrb);
    wait_resp(d, lat);
    rdata = resp_rdata[d];
    err   = resp_err[d];
    if (lat > 0) take_resp();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      asserts++;
      if ({req_ready[d], resp_valid[d], resp_err[d], resp_rdata[d]} !== 35'd0) begin
        fails++;
        $display("FAIL reset_outputs dut%0d: ready=%b valid=%b err=%b rdata=%h, expected all 0",
                 d, req_ready[d], resp_valid[d], resp_err[d], resp_rdata[d]);
      end
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    asserts++;
    if (req_ready[0] !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready_after: got %b expected 1", req_ready[0]);
    end
  endtask

  task automatic test_full_word();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    asserts++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
      fails++;
      $display("FAIL store_0x10: lat=%0d err=%b rdata=%h, expected lat=2 err=0 rdata=0", lat, er, rd);
    end
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    asserts++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL load_0x10: lat=%0d err=%b rdata=%h, expected lat=2 err=0 rdata=deadbeef", lat, er, rd);
    end
  endtask

  task automatic test_partial_strobe();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    txn(0, 1'b1, 32'h20, 32'h000000AA, 4'b0001, rd, er, lat);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    asserts++;
    if (rd !== 32'h112233AA || er !== 1'b0) begin
      fails++;
      $display("FAIL strobe_byte0: rdata=%h err=%b, expected 112233aa err=0", rd, er);
    end
    txn(0, 1'b1, 32'h22, 32'h0000BBCC, 4'b0011, rd, er, lat);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    asserts++;
    if (rd !== 32'h1122BBCC) begin
      fails++;
      $display("FAIL strobe_half_unaligned: rdata=%h, expected 1122bbcc", rd);
    end
    // Zero strobe: normal response, word untouched.
    txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    asserts++;
    if (lat !== 2 || er !== 1'b0) begin
      fails++;
      $display("FAIL strobe_zero_resp: lat=%0d err=%b, expected lat=2 err=0", lat, er);
    end
    txn(0, 1'b0, 32'h23, 32'h0, 4'h0, rd, er, lat);
    asserts++;
    if (rd !== 32'h1122BBCC) begin
      fails++;
      $display("FAIL strobe_zero_nowrite: rdata=%h, expected 1122bbcc", rd);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, 32'h0,   32'hA5A5A5A5, 4'hF, rd, er, lat);
    txn(0, 1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, rd, er, lat);
    asserts++;
    if (er !== 1'b0) begin
      fails++;
      $display("FAIL store_last_word_err: got %b expected 0", er);
    end
    txn(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, rd, er, lat);
    asserts++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
      fails++;
      $display("FAIL store_oor: err=%b rdata=%h lat=%0d, expected err=1 rdata=0 lat=2", er, rd, lat);
    end
    txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
    asserts++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      fails++;
      $display("FAIL load_oor: err=%b rdata=%h, expected err=1 rdata=0", er, rd);
    end
    txn(0, 1'b0, 32'hFFC, 32'h0, 4'h0, rd, er, lat);
    asserts++;
    if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL load_last_word: err=%b rdata=%h, expected err=0 rdata=cafef00d", er, rd);
    end
    // Word 0 would be hit if the faulting index wrapped.
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    asserts++;
    if (er !== 1'b0 || rd !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL oor_no_wrap: err=%b rdata=%h, expected err=0 rdata=a5a5a5a5", er, rd);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
    wait_resp(0, lat);
    asserts++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL bp_latency: got %0d expected 2", lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      asserts++;
      if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'hDEADBEEF || req_ready[0] !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold cycle %0d: valid=%b rdata=%h ready=%b, expected 1 deadbeef 0",
                 c, resp_valid[0], resp_rdata[0], req_ready[0]);
      end
    end
    take_resp();
    @(negedge clk);
    asserts++;
    if (resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'h0 || req_ready[0] !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: valid=%b rdata=%h ready=%b, expected 0 0 1",
               resp_valid[0], resp_rdata[0], req_ready[0]);
    end
  endtask

  task automatic test_wait_zero();
    logic [31:0] rd; logic er; int lat;
    txn(1, 1'b1, 32'h8, 32'h00000077, 4'hF, rd, er, lat);
    asserts++;
    if (lat !== 1 || er !== 1'b0) begin
      fails++;
      $display("FAIL w0_store: lat=%0d err=%b, expected lat=1 err=0", lat, er);
    end
    txn(1, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    asserts++;
    if (lat !== 1 || rd !== 32'h00000077) begin
      fails++;
      $display("FAIL w0_load: lat=%0d rdata=%h, expected lat=1 rdata=00000077", lat, rd);
    end
  endtask

  task automatic test_wait_three_reset();
    logic [31:0] rd; logic er; int lat;
    txn(2, 1'b1, 32'h40, 32'h99999999, 4'hF, rd, er, lat);
    asserts++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL w3_store_latency: got %0d expected 4", lat);
    end
    txn(2, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    asserts++;
    if (lat !== 4 || rd !== 32'h99999999) begin
      fails++;
      $display("FAIL w3_load: lat=%0d rdata=%h, expected lat=4 rdata=99999999", lat, rd);
    end
    // Store accepted, then reset while still in WAIT.
    send_req(2, 1'b1, 32'h40, 32'h00000055, 4'hF);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    asserts++;
    if (resp_valid[2] !== 1'b0) begin
      fails++;
      $display("FAIL w3_reset_valid: got %b expected 0", resp_valid[2]);
    end
    repeat (4) @(negedge clk);
    asserts++;
    if (resp_valid[2] !== 1'b0 || req_ready[2] !== 1'b1) begin
      fails++;
      $display("FAIL w3_reset_idle: valid=%b ready=%b, expected 0 1", resp_valid[2], req_ready[2]);
    end
    txn(2, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    asserts++;
    if (rd !== 32'h99999999 || lat !== 4) begin
      fails++;
      $display("FAIL w3_reset_nocommit: rdata=%h lat=%0d, expected 99999999 lat=4", rd, lat);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) req_valid[d] = 1'b0;
    test_reset();
    test_full_word();
    test_partial_strobe();
    test_out_of_range();
    test_backpressure();
    test_wait_zero();
    test_wait_three_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
